// File: rtl/udcnt_pkg.sv
// Shared types and constants for the up/down counter scheduler (udcnt_sched)
// and its round-robin arbiter.
package udcnt_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int STEP_W_DEF = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The priority pointer lives here and moves to
// the requester that was not just served whenever adv_i is strobed.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = ~owner_i;
    end
  end

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/udcnt_sched.sv
// Shares one up/down counter between two requesters: grants round-robin,
// drives CntE/CntU for N cycles, then pulses Ack. Optional macro SATURATE_EN
// stops a move early when the counter would wrap and flags it on Sat.
module udcnt_sched
  import udcnt_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [1:0]        Req,
  input  logic [1:0]        Dir,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  input  logic [CNT_W-1:0]  Cnt,
  output logic              CntE,
  output logic              CntU,
  output logic [1:0]        Ack,
  output logic              Busy,
  output logic [1:0]        Gnt,
  output logic              Sat
);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              sat_q, sat_d;
  logic [1:0]        arb_gnt;
  logic              adv;
  logic              sat_hit;
  logic              in_run;

  rr_arb2 u_arb (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .req_i   (Req),
    .adv_i   (adv),
    .owner_i (gnt_q[1]),
    .gnt_o   (arb_gnt)
  );

`ifdef SATURATE_EN
  // Stop before the counter would wrap in the latched direction.
  assign sat_hit = ((dir_q == DIR_UP) && (Cnt == {CNT_W{1'b1}})) ||
                   ((dir_q == DIR_DN) && (Cnt == {CNT_W{1'b0}}));
`else
  logic unused_cnt;
  assign unused_cnt = ^Cnt;
  assign sat_hit    = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_DN;
      steps_q <= '0;
      gnt_q   <= 2'b00;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      gnt_q   <= gnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    gnt_d   = gnt_q;
    sat_d   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req != 2'b00) begin
          gnt_d   = arb_gnt;
          dir_d   = arb_gnt[1] ? Dir[1] : Dir[0];
          steps_d = arb_gnt[1] ? Steps1 : Steps0;
          state_d = (steps_d != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (sat_hit) begin
          // Remaining steps are dropped; Sat rides along with the Ack.
          steps_d = '0;
          sat_d   = 1'b1;
          state_d = DONE;
        end else begin
          if (steps_q != '0) begin
            steps_d = steps_q - STEP_W'(1);
          end
          if (steps_q <= STEP_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        adv     = 1'b1;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        steps_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the state register; saturation can only suppress CntE.
  assign in_run = (state_q == RUN);
  assign CntE   = in_run && !sat_hit;
  assign CntU   = in_run && (dir_q == DIR_UP);
  assign Ack    = (state_q == DONE) ? gnt_q : 2'b00;
  assign Busy   = (state_q != IDLE);
  assign Gnt    = gnt_q;
  assign Sat    = sat_q;

  a_gnt_onehot0 : assert property (@(posedge Clk) disable iff (!Rst_n)
    $onehot0(gnt_q));
  a_gnt_when_busy : assert property (@(posedge Clk) disable iff (!Rst_n)
    (state_q != IDLE) |-> (gnt_q != 2'b00));
  a_idle_quiet : assert property (@(posedge Clk) disable iff (!Rst_n)
    (state_q == IDLE) |-> (gnt_q == 2'b00 && !sat_q));

endmodule

// File: tb/tb_udcnt_sched.sv
// Directed bench for udcnt_sched with a transaction-level model of the
// expected output timeline and an external counter standing in for the datapath.
module tb_udcnt_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic [3:0] steps0 = 4'd0;
  logic [3:0] steps1 = 4'd0;
  logic [3:0] cnt = 4'd0;
  logic       cnte, cntu, busy, sat;
  logic [1:0] ack, gnt;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  udcnt_sched #(.CNT_W(4), .STEP_W(4)) dut (
    .Clk    (clk),
    .Rst_n  (rst_n),
    .Req    (req),
    .Dir    (dir),
    .Steps0 (steps0),
    .Steps1 (steps1),
    .Cnt    (cnt),
    .CntE   (cnte),
    .CntU   (cntu),
    .Ack    (ack),
    .Busy   (busy),
    .Gnt    (gnt),
    .Sat    (sat)
  );

  // Counter datapath: wraps naturally, preloadable between tests.
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnte) cnt <= cntu ? cnt + 4'd1 : cnt - 4'd1;
  end

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Model: per-cycle vector {busy, gnt[1:0], cnte, cntu, ack[1:0], sat}.
  logic [7:0] exp_q[$];
  logic       mptr = 1'b0;

  always @(posedge clk) begin : model
    logic       w, d, hit;
    logic [1:0] g;
    int         n, run_n, lim;
    if (rst_n && exp_q.size() == 0 && req != 2'b00) begin
      w     = (req == 2'b11) ? mptr : req[1];
      g     = w ? 2'b10 : 2'b01;
      d     = dir[w];
      n     = w ? int'(steps1) : int'(steps0);
      run_n = n;
      hit   = 1'b0;
      lim   = 0;
`ifdef SATURATE_EN
      lim = d ? (15 - int'(cnt)) : int'(cnt);
      if (n > lim) begin
        run_n = lim;
        hit   = 1'b1;
      end
`endif
      for (int i = 0; i < run_n; i++) exp_q.push_back({1'b1, g, 1'b1, d, 2'b00, 1'b0});
      if (hit) exp_q.push_back({1'b1, g, 1'b0, d, 2'b00, 1'b0});
      exp_q.push_back({1'b1, g, 1'b0, 1'b0, g, hit});
      exp_q.push_back(8'h00);
      mptr = ~w;
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    mptr = 1'b0;
  end

  always @(negedge clk) begin : compare
    logic [7:0] e;
    if (rst_n) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check_int("cycle_outputs", int'({busy, gnt, cnte, cntu, ack, sat}), int'(e));
    end
  end

  int         acks_got, cnte_cyc, busy_cyc, ack_lat, sat_seen;
  logic [1:0] ack_log[$];
  logic [3:0] cnt_log[$];
  int         ack_cyc[$];

  task automatic run_txn(input int n, input bit drop);
    int cyc;
    logic [1:0] pending;
    cyc = 0;
    acks_got = 0; cnte_cyc = 0; busy_cyc = 0; ack_lat = -1; sat_seen = 0;
    ack_log.delete(); cnt_log.delete(); ack_cyc.delete();
    while (acks_got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cnte) cnte_cyc++;
      if (busy) busy_cyc++;
      pending = ack;
      if (ack != 2'b00) begin
        ack_log.push_back(ack);
        cnt_log.push_back(cnt);
        ack_cyc.push_back(cyc);
        acks_got++;
        if (ack_lat < 0) ack_lat = cyc;
        if (sat) sat_seen++;
      end
      @(posedge clk); #1;
      if (drop) req = req & ~pending;
    end
    req = 2'b00;
    check_int("txn_ack_count", acks_got, n);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] v);
    @(posedge clk); #1;
    load = 1'b1; load_val = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  function automatic int log_ack(input int i);
    return (i < ack_log.size()) ? int'(ack_log[i]) : -1;
  endfunction

  function automatic int log_cnt(input int i);
    return (i < cnt_log.size()) ? int'(cnt_log[i]) : -1;
  endfunction

  initial begin
    int c, k, c0;
    #2 rst_n = 1'b0;
    #1 check_int("reset_outputs", int'({busy, gnt, cnte, cntu, ack, sat}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Single request, counter 2, up 3.
    preload(4'd2);
    dir = 2'b01; steps0 = 4'd3; req = 2'b01;
    run_txn(1, 1'b1);
    check_int("single_ack_lat", ack_lat, 5);
    check_int("single_cnte_cycles", cnte_cyc, 3);
    check_int("single_busy_cycles", busy_cyc, 4);
    check_int("single_ack", log_ack(0), 1);
    check_int("single_cnt_end", log_cnt(0), 5);
    idle(2);

    // Abort mid-RUN after two CntE cycles.
    dir = 2'b01; steps0 = 4'd5; req = 2'b01;
    c = 0; k = 0;
    while (c < 2 && k < 20) begin
      @(negedge clk);
      k++;
      if (cnte) c++;
    end
    check_int("rst_run_reached", c, 2);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 2'b00;
    #1 check_int("rst_midrun_outputs", int'({busy, gnt, cnte, cntu, ack, sat}), 0);
    repeat (2) begin
      @(negedge clk);
      check_int("rst_hold_outputs", int'({busy, gnt, cnte, cntu, ack, sat}), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Contention: requester 0 wins because reset returned the pointer to 0.
    preload(4'd7);
    dir = 2'b01; steps0 = 4'd2; steps1 = 4'd4; req = 2'b11;
    run_txn(2, 1'b1);
    check_int("cont_ack0", log_ack(0), 1);
    check_int("cont_ack1", log_ack(1), 2);
    check_int("cont_cnt0", log_cnt(0), 9);
    check_int("cont_cnt1", log_cnt(1), 5);
    check_int("cont_ack_cyc0", (ack_cyc.size() > 0) ? ack_cyc[0] : -1, 4);
    check_int("cont_ack_cyc1", (ack_cyc.size() > 1) ? ack_cyc[1] : -1, 10);
    idle(2);

    // Wrap (or saturate) from 14 going up 3.
    preload(4'd14);
    dir = 2'b01; steps0 = 4'd3; req = 2'b01;
    run_txn(1, 1'b1);
    check_int("wrap_ack", log_ack(0), 1);
`ifdef SATURATE_EN
    check_int("sat_cnte_cycles", cnte_cyc, 1);
    check_int("sat_cnt_end", log_cnt(0), 15);
    check_int("sat_flag", sat_seen, 1);
    check_int("sat_ack_lat", ack_lat, 4);
`else
    check_int("wrap_cnte_cycles", cnte_cyc, 3);
    check_int("wrap_cnt_end", log_cnt(0), 1);
    check_int("wrap_sat", sat_seen, 0);
    check_int("wrap_ack_lat", ack_lat, 5);
`endif
    idle(2);

    // Zero-step request from requester 1.
    c0 = int'(cnt);
    dir = 2'b00; steps1 = 4'd0; req = 2'b10;
    run_txn(1, 1'b1);
    check_int("zero_ack_lat", ack_lat, 2);
    check_int("zero_cnte_cycles", cnte_cyc, 0);
    check_int("zero_ack", log_ack(0), 2);
    check_int("zero_cnt_same", log_cnt(0), c0);
    check_int("zero_sat", sat_seen, 0);
    idle(2);

    // Fairness: both requests held for six transactions.
    c0 = int'(cnt);
    dir = 2'b01; steps0 = 4'd1; steps1 = 4'd1; req = 2'b11;
    run_txn(6, 1'b0);
    for (int i = 0; i < 6; i++) check_int("fair_ack", log_ack(i), (i % 2 == 0) ? 1 : 2);
    check_int("fair_cnt_net", log_cnt(5), c0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
